// File: rtl/nexys_starship_monster_ctrl.sv
// Four-lane monster game controller: spawn, timeout, shoot/kill scoring and game FSM.
// All outputs are registered; lane state changes only while a game is in play.
module nexys_starship_monster_ctrl #(
  parameter int unsigned TIMEOUT_TICKS = 10,
  parameter int unsigned SCORE_MAX     = 99
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        start,
  input  logic        tick,
  input  logic [3:0]  spawn_req,
  input  logic [3:0]  spawn_hex,
  input  logic [3:0]  shoot,
  input  logic [3:0]  shoot_code,
  output logic [3:0]  monster_active,
  output logic [15:0] monster_code,
  output logic [7:0]  score,
  output logic        kill_pulse,
  output logic        wrong_pulse,
  output logic [1:0]  game_state
);

  localparam int unsigned LANES   = 4;
  localparam int unsigned CODE_W  = 4;
  localparam int unsigned TMR_W   = 8;
  localparam int unsigned SCORE_W = 8;
  localparam int unsigned SUM_W   = SCORE_W + 1;
  localparam int unsigned KILL_W  = 3;

  localparam logic [TMR_W-1:0]   LAST_TICK = TMR_W'(TIMEOUT_TICKS - 1);
  localparam logic [SUM_W-1:0]   SCORE_CAP = SUM_W'(SCORE_MAX);

  typedef enum logic [1:0] {
    ST_READY = 2'b00,
    ST_PLAY  = 2'b01,
    ST_OVER  = 2'b10
  } state_e;

  state_e                         state_q, state_d;
  logic [LANES-1:0]               active_q, active_d;
  logic [LANES-1:0][CODE_W-1:0]   code_q, code_d;
  logic [LANES-1:0][TMR_W-1:0]    timer_q, timer_d;
  logic [SCORE_W-1:0]             score_q, score_d;
  logic                           kill_q, kill_d;
  logic                           wrong_q, wrong_d;

  logic [LANES-1:0]               hit, miss, expire;
  logic [KILL_W-1:0]              n_kill;
  logic [SUM_W-1:0]               score_sum;

  // Per-lane shot/timeout classification; a matching shot suppresses expiry.
  always_comb begin
    hit    = '0;
    miss   = '0;
    expire = '0;
    n_kill = '0;
    for (int i = 0; i < LANES; i++) begin
      hit[i]    = active_q[i] && shoot[i] && (shoot_code == code_q[i]);
      miss[i]   = active_q[i] && shoot[i] && (shoot_code != code_q[i]);
      expire[i] = active_q[i] && tick && (timer_q[i] == LAST_TICK) && !hit[i];
      n_kill    = n_kill + KILL_W'(hit[i]);
    end
  end

  always_comb begin
    state_d   = state_q;
    active_d  = active_q;
    code_d    = code_q;
    timer_d   = timer_q;
    score_d   = score_q;
    kill_d    = 1'b0;
    wrong_d   = 1'b0;
    score_sum = SUM_W'(score_q) + SUM_W'(n_kill);

    case (state_q)
      ST_READY, ST_OVER: begin
        if (start) begin
          state_d  = ST_PLAY;
          active_d = '0;
          code_d   = '0;
          timer_d  = '0;
          score_d  = '0;
        end
      end
      ST_PLAY: begin
        for (int i = 0; i < LANES; i++) begin
          if (hit[i]) begin
            active_d[i] = 1'b0;
            code_d[i]   = '0;
            timer_d[i]  = '0;
          end else if (!active_q[i]) begin
            if (spawn_req[i]) begin
              active_d[i] = 1'b1;
              code_d[i]   = spawn_hex;
              timer_d[i]  = '0;
            end
          end else if (tick) begin
            timer_d[i] = timer_q[i] + TMR_W'(1);
          end
        end
        score_d = (score_sum > SCORE_CAP) ? SCORE_W'(SCORE_MAX) : score_sum[SCORE_W-1:0];
        kill_d  = |hit;
        wrong_d = |miss;
        // Expiry outranks a coincident start; start is ignored in play.
        if (|expire) state_d = ST_OVER;
      end
      default: state_d = ST_READY;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= ST_READY;
      active_q <= '0;
      code_q   <= '0;
      timer_q  <= '0;
      score_q  <= '0;
      kill_q   <= 1'b0;
      wrong_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      code_q   <= code_d;
      timer_q  <= timer_d;
      score_q  <= score_d;
      kill_q   <= kill_d;
      wrong_q  <= wrong_d;
    end
  end

  assign monster_active = active_q;
  assign monster_code   = code_q;
  assign score          = score_q;
  assign kill_pulse     = kill_q;
  assign wrong_pulse    = wrong_q;
  assign game_state     = state_q;

endmodule

// File: tb/tb_nexys_starship_monster_ctrl.sv
// Bench for nexys_starship_monster_ctrl: directed game scenarios then random play,
// every cycle checked against a lane/score model kept in plain arrays.
module tb_nexys_starship_monster_ctrl;

  localparam int unsigned T    = 3;
  localparam int unsigned SMAX = 99;

  logic        Clk;
  logic        Reset;
  logic        start;
  logic        tick;
  logic [3:0]  spawn_req;
  logic [3:0]  spawn_hex;
  logic [3:0]  shoot;
  logic [3:0]  shoot_code;
  logic [3:0]  monster_active;
  logic [15:0] monster_code;
  logic [7:0]  score;
  logic        kill_pulse;
  logic        wrong_pulse;
  logic [1:0]  game_state;

  int checks = 0;
  int errors = 0;

  // Reference model: 0 ready, 1 play, 2 over.
  int         m_state;
  bit         m_active [4];
  logic [3:0] m_code   [4];
  int         m_age    [4];
  int         m_score;
  bit         m_kp;
  bit         m_wp;

  nexys_starship_monster_ctrl #(
    .TIMEOUT_TICKS (T),
    .SCORE_MAX     (SMAX)
  ) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .start          (start),
    .tick           (tick),
    .spawn_req      (spawn_req),
    .spawn_hex      (spawn_hex),
    .shoot          (shoot),
    .shoot_code     (shoot_code),
    .monster_active (monster_active),
    .monster_code   (monster_code),
    .score          (score),
    .kill_pulse     (kill_pulse),
    .wrong_pulse    (wrong_pulse),
    .game_state     (game_state)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic m_clear_lanes();
    for (int i = 0; i < 4; i++) begin
      m_active[i] = 1'b0;
      m_code[i]   = 4'h0;
      m_age[i]    = 0;
    end
  endtask

  task automatic m_reset();
    m_state = 0;
    m_clear_lanes();
    m_score = 0;
    m_kp    = 1'b0;
    m_wp    = 1'b0;
  endtask

  task automatic model_step(input logic st, input logic tk, input logic [3:0] sr,
                            input logic [3:0] sx, input logic [3:0] sh, input logic [3:0] sc);
    int kills;
    bit wrong;
    bit lost;
    kills = 0;
    wrong = 1'b0;
    lost  = 1'b0;
    if (m_state != 1) begin
      if (st) begin
        m_state = 1;
        m_clear_lanes();
        m_score = 0;
      end
      m_kp = 1'b0;
      m_wp = 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (m_active[i]) begin
          if (sh[i] && sc == m_code[i]) begin
            kills++;
            m_active[i] = 1'b0;
            m_code[i]   = 4'h0;
            m_age[i]    = 0;
          end else begin
            if (sh[i]) wrong = 1'b1;
            if (tk) begin
              if (m_age[i] == int'(T) - 1) lost = 1'b1;
              m_age[i]++;
            end
          end
        end else if (sr[i]) begin
          m_active[i] = 1'b1;
          m_code[i]   = sx;
          m_age[i]    = 0;
        end
      end
      m_score = (m_score + kills > int'(SMAX)) ? int'(SMAX) : m_score + kills;
      m_kp    = (kills > 0);
      m_wp    = wrong;
      if (lost) m_state = 2;
    end
  endtask

  task automatic chk(input string tag, input string what, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s observed=%0h expected=%0h", tag, what, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [15:0] exp_code;
    logic [3:0]  exp_act;
    for (int i = 0; i < 4; i++) begin
      exp_code[4*i +: 4] = m_code[i];
      exp_act[i]         = m_active[i];
    end
    chk(tag, "state",  16'(game_state),     16'(m_state));
    chk(tag, "active", 16'(monster_active), 16'(exp_act));
    chk(tag, "code",   monster_code,        exp_code);
    chk(tag, "score",  16'(score),          16'(m_score));
    chk(tag, "kill",   16'(kill_pulse),     16'(m_kp));
    chk(tag, "wrong",  16'(wrong_pulse),    16'(m_wp));
  endtask

  // One clock: drive at the falling edge, step model at the rising edge, check at the next fall.
  task automatic cycle(input string tag, input logic st, input logic tk, input logic [3:0] sr,
                       input logic [3:0] sx, input logic [3:0] sh, input logic [3:0] sc);
    start = st; tick = tk; spawn_req = sr; spawn_hex = sx; shoot = sh; shoot_code = sc;
    @(posedge Clk);
    model_step(st, tk, sr, sx, sh, sc);
    @(negedge Clk);
    start = 1'b0; tick = 1'b0; spawn_req = 4'h0; shoot = 4'h0;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    cycle(tag, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
  endtask

  initial begin
    logic [3:0] r_sr, r_sx, r_sh, r_sc;
    logic       r_st, r_tk;

    Reset = 1'b1; start = 1'b0; tick = 1'b0;
    spawn_req = 4'h0; spawn_hex = 4'h0; shoot = 4'h0; shoot_code = 4'h0;
    m_reset();
    @(negedge Clk);
    @(negedge Clk);
    check_all("reset");
    Reset = 1'b0;
    idle("ready_hold");

    // Start, then spawn lane 0 with code A.
    cycle("start", 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    cycle("req034", 1'b0, 1'b0, 4'b0001, 4'hA, 4'h0, 4'h0);
    chk("req034", "state",  16'(game_state), 16'h1);
    chk("req034", "active", 16'(monster_active), 16'h1);
    chk("req034", "code0",  16'(monster_code[3:0]), 16'hA);

    // Matching shot on lane 0.
    cycle("req035", 1'b0, 1'b0, 4'h0, 4'h0, 4'b0001, 4'hA);
    chk("req035", "active", 16'(monster_active), 16'h0);
    chk("req035", "score",  16'(score), 16'h1);
    chk("req035", "kill",   16'(kill_pulse), 16'h1);
    idle("req035_after");
    chk("req035", "kill_drop", 16'(kill_pulse), 16'h0);

    // Wrong code on lane 2.
    cycle("spawn2", 1'b0, 1'b0, 4'b0100, 4'h5, 4'h0, 4'h0);
    cycle("req036", 1'b0, 1'b0, 4'h0, 4'h0, 4'b0100, 4'h3);
    chk("req036", "wrong",  16'(wrong_pulse), 16'h1);
    chk("req036", "active", 16'(monster_active), 16'b0100);
    chk("req036", "code2",  16'(monster_code[11:8]), 16'h5);
    chk("req036", "score",  16'(score), 16'h1);

    // Shot on idle lane 0 with same-cycle spawn; spawn on busy lane 2 ignored.
    cycle("idle_shot", 1'b0, 1'b0, 4'b0101, 4'h4, 4'b0001, 4'h4);
    chk("idle_shot", "active", 16'(monster_active), 16'b0101);
    chk("idle_shot", "code2",  16'(monster_code[11:8]), 16'h5);
    cycle("clr", 1'b0, 1'b0, 4'h0, 4'h0, 4'b0101, 4'h5);
    cycle("clr", 1'b0, 1'b0, 4'h0, 4'h0, 4'b0001, 4'h4);

    // Timeout on lane 1, then frozen in OVER, then restart.
    cycle("spawn1", 1'b0, 1'b0, 4'b0010, 4'hC, 4'h0, 4'h0);
    cycle("tick1", 1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0);
    idle("gap");
    cycle("tick2", 1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0);
    chk("req037", "still_play", 16'(game_state), 16'h1);
    cycle("tick3", 1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0);
    chk("req037", "over",   16'(game_state), 16'h2);
    chk("req037", "active", 16'(monster_active), 16'b0010);
    cycle("frozen", 1'b0, 1'b1, 4'hF, 4'h9, 4'b0010, 4'hC);
    chk("req037", "frozen_active", 16'(monster_active), 16'b0010);
    chk("req037", "frozen_kill",   16'(kill_pulse), 16'h0);
    cycle("restart", 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    chk("req037", "restart_state",  16'(game_state), 16'h1);
    chk("req037", "restart_active", 16'(monster_active), 16'h0);
    chk("req037", "restart_score",  16'(score), 16'h0);

    // Matching shot beats expiry on lane 3.
    cycle("spawn3", 1'b0, 1'b0, 4'b1000, 4'h7, 4'h0, 4'h0);
    cycle("t", 1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0);
    cycle("t", 1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0);
    cycle("req038a", 1'b0, 1'b1, 4'h0, 4'h0, 4'b1000, 4'h7);
    chk("req038a", "state", 16'(game_state), 16'h1);
    chk("req038a", "kill",  16'(kill_pulse), 16'h1);

    // Build score to 97, then a four-lane kill saturates at 99.
    for (int r = 0; r < 24; r++) begin
      cycle("fill_spawn", 1'b0, 1'b0, 4'hF, 4'(r), 4'h0, 4'h0);
      cycle("fill_kill",  1'b0, 1'b0, 4'h0, 4'h0, 4'hF, 4'(r));
    end
    chk("req038b", "score97", 16'(score), 16'd97);
    cycle("sat_spawn", 1'b0, 1'b0, 4'hF, 4'h9, 4'h0, 4'h0);
    cycle("sat_kill",  1'b0, 1'b0, 4'h0, 4'h0, 4'hF, 4'h9);
    chk("req038b", "score99", 16'(score), 16'd99);
    cycle("sat2_spawn", 1'b0, 1'b0, 4'b0001, 4'h2, 4'h0, 4'h0);
    cycle("sat2_kill",  1'b0, 1'b0, 4'h0, 4'h0, 4'b0001, 4'h2);
    chk("sat", "score_held", 16'(score), 16'd99);
    chk("sat", "kill_pulse", 16'(kill_pulse), 16'h1);

    // Random play against the model.
    for (int n = 0; n < 3000; n++) begin
      r_st = ($urandom_range(0, 29) == 0);
      r_tk = ($urandom_range(0, 5) == 0);
      r_sr = 4'($urandom) & 4'($urandom);
      r_sx = 4'($urandom);
      r_sh = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      r_sc = ($urandom_range(0, 1) == 1) ? m_code[$urandom_range(0, 3)] : 4'($urandom);
      cycle("rand", r_st, r_tk, r_sr, r_sx, r_sh, r_sc);
    end

    // Mid-clock asynchronous reset with three lanes active.
    Reset = 1'b1;
    m_reset();
    @(negedge Clk);
    Reset = 1'b0;
    check_all("rst2");
    cycle("start3", 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    cycle("spawn3l", 1'b0, 1'b0, 4'b0111, 4'hB, 4'h0, 4'h0);
    chk("req039", "pre_active", 16'(monster_active), 16'b0111);
    @(posedge Clk);
    #2;
    Reset = 1'b1;
    m_reset();
    #1;
    check_all("req039");
    chk("req039", "state", 16'(game_state), 16'h0);
    @(negedge Clk);
    Reset = 1'b0;
    cycle("post_rst", 1'b0, 1'b1, 4'hF, 4'h3, 4'hF, 4'h3);
    chk("post_rst", "ready", 16'(game_state), 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nexys_starship_monster_ctrl.md
NEXYS_STARSHIP_MONSTER_CTRL -- requirements
Module: nexys_starship_monster_ctrl

Interface
REQ-001 Parameter TIMEOUT_TICKS, default 10: tick pulses a monster survives before the game is lost; legal range 1-255.
REQ-002 Parameter SCORE_MAX, default 99: saturation value of score.
REQ-003 Clk  input  1  system clock; all state on rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse; begins a new game.
REQ-006 tick  input  1  one-cycle timebase pulse for lane timers.
REQ-007 spawn_req  input  4  per-lane spawn request {right,left,btm,top}, from the PRNG random bits.
REQ-008 spawn_hex  input  4  PRNG random_hex value, captured as the monster code at spawn.
REQ-009 shoot  input  4  per-lane one-cycle debounced fire pulse, same bit order.
REQ-010 shoot_code  input  4  player switch value compared against the monster code.
REQ-011 monster_active  output  4  lane occupied, same bit order.
REQ-012 monster_code  output  16  lane codes packed; lane i in bits [4i+3:4i].
REQ-013 score  output  8  monsters destroyed this game, saturating.
REQ-014 kill_pulse  output  1  one-cycle pulse when at least one monster is destroyed.
REQ-015 wrong_pulse  output  1  one-cycle pulse when a shot hits an active lane with a mismatched code.
REQ-016 game_state  output  2  00 READY, 01 PLAY, 10 OVER.

Function
REQ-017 Game FSM: READY -start-> PLAY; PLAY -any lane expiry-> OVER; OVER -start-> PLAY; all other inputs hold state.
REQ-018 Entering PLAY: all lanes cleared, codes zeroed, timers zeroed, score zeroed, in the same edge as the transition.
REQ-019 Lanes change only in PLAY; in READY and OVER, spawn_req and shoot are ignored and lane state is frozen (OVER keeps the final display).
REQ-020 Spawn: idle lane i with spawn_req[i]=1 goes active next edge; code <= spawn_hex; timer <= 0; multiple lanes may spawn in the same cycle with the same code.
REQ-021 spawn_req on an already-active lane is ignored; its code and timer are unchanged.
REQ-022 Timer: an active lane increments its 8-bit timer on each tick.
REQ-023 Expiry: an active lane with timer = TIMEOUT_TICKS-1, tick=1, and no matching shot that cycle causes PLAY->OVER next edge; monster_active stays 1 for that lane.
REQ-024 Kill: shoot[i]=1 on an active lane with shoot_code = code[i] clears the lane next edge (active 0, code 0, timer 0).
REQ-025 A kill takes priority over expiry in the same cycle.
REQ-026 Mismatch: shoot[i]=1 on an active lane with a wrong code has no lane effect; wrong_pulse=1 next cycle.
REQ-027 shoot[i] on an idle lane is ignored; a same-cycle spawn on that lane still takes effect.
REQ-028 Score: add the number of lanes killed in the cycle (0-4); saturate at SCORE_MAX.
REQ-029 kill_pulse: asserted the cycle after any kill; it pulses even when score is saturated.
REQ-030 Latency: all outputs are registered and reflect inputs sampled at the previous edge; there is no combinational input-to-output path.
REQ-031 If start arrives in PLAY it is ignored; expiry and start in the same cycle in PLAY: expiry wins (->OVER).

Reset
REQ-032 Reset forces READY, monster_active=0, monster_code=0, all timers=0, score=0, kill_pulse=0, wrong_pulse=0, immediately and independent of Clk.
REQ-033 Reset asserted mid-game abandons all lanes; after release the block waits in READY for start.

Verification
REQ-034 Reset, start, spawn_req=0001 with spawn_hex=A -> game_state=01, monster_active=0001, monster_code[3:0]=A.
REQ-035 Lane 0 active with code A, shoot=0001 and shoot_code=A -> next cycle monster_active=0000, score=1, kill_pulse=1 for exactly one cycle.
REQ-036 Lane 2 active with code 5, shoot_code=3 and shot -> wrong_pulse=1, lane stays active with code 5, score unchanged.
REQ-037 TIMEOUT_TICKS=3, lane 1 spawned, 3 tick pulses with no shots -> game_state=10 after the third tick; later spawn_req and shoot have no effect; start -> PLAY with lanes and score cleared.
REQ-038 Lane 3 timer at TIMEOUT_TICKS-1 with tick and a matching shot in the same cycle -> kill, game remains PLAY; four lanes killed in one cycle with score=97 -> score=99.
REQ-039 Assert Reset mid-clock during PLAY with 3 lanes active -> outputs 0 and game_state=00 before the next edge.
